// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// almost-full/almost-empty thresholds plus over/underflow pulses.
module sync_fifo #(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_LVL  = (2 ** ADDR_WIDTH) - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_WIDTH-1:0]  datain,
  input  logic                  wr,
  input  logic                  rd,
  output logic [BUS_WIDTH-1:0]  dataout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AFULL_C  = AFULL_LVL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = AEMPTY_LVL[ADDR_WIDTH:0];

  logic [BUS_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // A write into a full FIFO is legal only when a read frees a slot on the same edge.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      dataout   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr & ~wr_ok;
      underflow <= rd & ~rd_ok;
      if (wr_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_ok) begin
        dataout <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo at default parameters: vector table for count and
// pulses, queue scoreboard for read data, hand-written reset sequence.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] datain;
  logic        wr;
  logic        rd;
  logic [15:0] dataout;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  sync_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .datain       (datain),
    .wr           (wr),
    .rd           (rd),
    .dataout      (dataout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] din;
    int          cnt;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] mdl[$];
  logic [15:0] exp_q[$];
  logic [15:0] last_dout;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_status(input int idx, input int cnt, input logic ovf, input logic udf);
    check("count", idx, 32'(count), 32'(cnt));
    check("full", idx, 32'(full), 32'(cnt == 8));
    check("empty", idx, 32'(empty), 32'(cnt == 0));
    check("almost_full", idx, 32'(almost_full), 32'(cnt >= 7));
    check("almost_empty", idx, 32'(almost_empty), 32'(cnt <= 1));
    check("overflow", idx, 32'(overflow), 32'(ovf));
    check("underflow", idx, 32'(underflow), 32'(udf));
  endtask

  function automatic void add(input logic w, input logic r, input logic [15:0] d,
                              input int c, input logic o, input logic u);
    vec_t v;
    v.wr = w; v.rd = r; v.din = d; v.cnt = c; v.ovf = o; v.udf = u;
    vecs.push_back(v);
  endfunction

  task automatic apply(input int idx, input vec_t v);
    bit rd_ok;
    bit wr_ok;
    @(negedge clk);
    wr = v.wr;
    rd = v.rd;
    datain = v.din;
    rd_ok = v.rd && (mdl.size() > 0);
    wr_ok = v.wr && ((mdl.size() < 8) || rd_ok);
    if (rd_ok) exp_q.push_back(mdl.pop_front());
    if (wr_ok) mdl.push_back(v.din);
    @(posedge clk);
    #1;
    check_status(idx, v.cnt, v.ovf, v.udf);
    if (rd_ok) last_dout = exp_q.pop_front();
    check("dataout", idx, 32'(dataout), 32'(last_dout));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    // fill, overflow, idle
    for (int i = 1; i <= 8; i++) add(1, 0, 16'(i), i, 0, 0);
    add(1, 0, 16'hDEAD, 8, 1, 0);
    add(0, 0, 16'h0000, 8, 0, 0);
    // drain, underflow, idle
    for (int i = 1; i <= 8; i++) add(0, 1, 16'h0000, 8 - i, 0, 0);
    add(0, 1, 16'h0000, 0, 0, 1);
    add(0, 0, 16'h0000, 0, 0, 0);
    // write+read while empty
    add(1, 1, 16'h00AA, 1, 0, 1);
    add(0, 1, 16'h0000, 0, 0, 0);
    // prime to 3 then 20 cycles of concurrent traffic across the wrap
    for (int i = 0; i < 3; i++) add(1, 0, 16'(16'h0100 + i), i + 1, 0, 0);
    for (int i = 3; i < 23; i++) add(1, 1, 16'(16'h0100 + i), 3, 0, 0);
    // fill, then write+read while full
    for (int i = 0; i < 5; i++) add(1, 0, 16'(16'h0200 + i), 4 + i, 0, 0);
    add(1, 1, 16'hBEEF, 8, 0, 0);
    add(0, 0, 16'h0000, 8, 0, 0);
    // drain down to 5 for the reset case
    for (int i = 0; i < 3; i++) add(0, 1, 16'h0000, 7 - i, 0, 0);

    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; datain = '0;
    repeat (2) @(posedge clk);
    #1;
    check_status(-1, 0, 0, 0);
    check("dataout_reset", -1, 32'(dataout), 32'h0);
    last_dout = '0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(i, vecs[i]);

    // reset mid-operation with a write pending
    @(negedge clk);
    rst_n = 1'b0; wr = 1'b1; rd = 1'b0; datain = 16'h5555;
    @(posedge clk);
    #1;
    check_status(1000, 0, 0, 0);
    check("dataout_midreset", 1000, 32'(dataout), 32'h0);
    mdl.delete();
    exp_q.delete();
    last_dout = '0;
    @(negedge clk);
    rst_n = 1'b1; wr = 1'b0;
    begin
      vec_t v;
      v.wr = 0; v.rd = 1; v.din = '0; v.cnt = 0; v.ovf = 0; v.udf = 1;
      apply(1001, v);
      v.wr = 1; v.rd = 0; v.din = 16'h1234; v.cnt = 1; v.udf = 0;
      apply(1002, v);
      v.wr = 0; v.rd = 1; v.din = '0; v.cnt = 0;
      apply(1003, v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, with depth DEPTH = 2**ADDR_WIDTH words; legal range 1..10.
REQ-003 SHALL have parameter AFULL_LVL, default DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_LVL, default 1, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port datain  input  BUS_WIDTH  write data.
REQ-008 SHALL have port wr  input  1  write request, sampled each clk edge.
REQ-009 SHALL have port rd  input  1  read request, sampled each clk edge.
REQ-010 SHALL have port dataout  output  BUS_WIDTH  registered read data.
REQ-011 SHALL have port full  output  1  high when occupancy == DEPTH.
REQ-012 SHALL have port empty  output  1  high when occupancy == 0.
REQ-013 SHALL have port almost_full  output  1  high when occupancy >= AFULL_LVL.
REQ-014 SHALL have port almost_empty  output  1  high when occupancy <= AEMPTY_LVL.
REQ-015 SHALL have port count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 SHALL have port overflow  output  1  one-cycle pulse on rejected write.
REQ-017 SHALL have port underflow  output  1  one-cycle pulse on rejected read.

Function
REQ-018 SHALL store words in a DEPTH-entry array addressed by ADDR_WIDTH-bit write and read pointers, each wrapping DEPTH-1 -> 0.
REQ-019 SHALL accept a write when wr=1 and (full=0 or read accepted same cycle); accepted write stores datain at wptr, wptr+1.
REQ-020 SHALL accept a read when rd=1 and empty=0; accepted read loads mem[rptr] into dataout on that edge (1-cycle latency), rptr+1.
REQ-021 SHALL hold dataout unchanged on cycles with no accepted read.
REQ-022 SHALL, on simultaneous accepted read and write, leave count unchanged; when full, both accepted.
REQ-023 SHALL, on wr=1 and rd=1 while empty, accept the write only (no bypass), count 0 -> 1, underflow pulse.
REQ-024 SHALL update count +1 on write-only, -1 on read-only, never exceeding DEPTH or going below 0.
REQ-025 SHALL derive full, empty, almost_full, almost_empty from registered count, valid in the cycle after the causing edge.
REQ-026 SHALL pulse overflow for exactly one cycle (the cycle after) when wr=1 is rejected; FIFO contents and pointers unchanged.
REQ-027 SHALL pulse underflow for exactly one cycle (the cycle after) when rd=1 is rejected; dataout unchanged.
REQ-028 SHALL preserve FIFO order exactly across pointer wrap-around.

Reset
REQ-029 SHALL, when rst_n=0 at a clk edge, set wptr=0, rptr=0, count=0, dataout=0, overflow=0, underflow=0, hence empty=1, full=0, almost_empty=1, almost_full=0 (for AFULL_LVL>0).
REQ-030 SHALL let reset take priority over simultaneous wr/rd; a reset mid-operation discards all stored words.
REQ-031 SHALL not require reset of the storage array.

Verification
REQ-032 SHALL cover fill: defaults, write 0x0001..0x0008 on 8 cycles -> count=8, full=1, almost_full=1 from count 7; 9th write 0xDEAD -> overflow pulse, count stays 8.
REQ-033 SHALL cover drain: from full, rd 8 cycles -> dataout 0x0001..0x0008 each one cycle after rd, empty=1 after last; extra rd -> underflow pulse, dataout stays 0x0008.
REQ-034 SHALL cover wrap: 20 cycles of wr+rd with count held at 3, data incrementing -> output sequence in order, no flag pulses, count stays 3.
REQ-035 SHALL cover empty corner: wr=1, rd=1, datain=0x00AA while empty -> count=1, underflow pulse, next rd returns 0x00AA.
REQ-036 SHALL cover full corner: wr=1, rd=1 while full -> oldest word read, new word stored, count=8, no overflow.
REQ-037 SHALL cover reset mid-operation: count=5, assert rst_n=0 one cycle with wr=1 -> count=0, empty=1, dataout=0, subsequent rd -> underflow.
